// File: rtl/tlb_refill_walker.sv
// Two-level hardware page-table walker servicing ITLB/DTLB misses.
// Reads PTEs over a 20-bit memory port, then issues a TLB write or a page fault.
module tlb_refill_walker #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [19:0] ptbr,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_vaddr,
    input  logic        miss_is_instr,
    input  logic        miss_user,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        tlb_write,
    output logic        tlb_sel_itlb,
    output logic [31:0] tlb_logic_page,
    output logic [19:0] tlb_physical_page,
    output logic        page_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_vaddr,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_DONE,
        S_FAULT,
        S_DRAIN
    } state_t;

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b00;
    localparam logic [1:0] CAUSE_L1      = 2'b01;
    localparam logic [1:0] CAUSE_L2      = 2'b10;
    localparam logic [1:0] CAUSE_PERM    = 2'b11;

    // Counter value seen in the last request cycle that may still be acked.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] vaddr_q;
    logic        is_instr_q;
    logic        user_q;
    logic [19:0] addr_q;
    logic [7:0]  frame_q;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] cnt_q;

    logic accept, load_l2, load_frame, load_cause;
    logic timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        load_l2    = 1'b0;
        load_frame = 1'b0;
        load_cause = 1'b0;
        cause_d    = CAUSE_TIMEOUT;
        case (state_q)
            S_IDLE: begin
                if (miss_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = S_L1;
                end
            end
            S_L1: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else if (!mem_rdata[0]) begin
                        state_d    = S_FAULT;
                        load_cause = 1'b1;
                        cause_d    = CAUSE_L1;
                    end else begin
                        load_l2 = 1'b1;
                        state_d = S_L2;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    state_d    = S_FAULT;
                    load_cause = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_L2: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else if (!mem_rdata[0]) begin
                        state_d    = S_FAULT;
                        load_cause = 1'b1;
                        cause_d    = CAUSE_L2;
                    end else if (user_q && !mem_rdata[1]) begin
                        state_d    = S_FAULT;
                        load_cause = 1'b1;
                        cause_d    = CAUSE_PERM;
                    end else begin
                        load_frame = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    state_d    = S_FAULT;
                    load_cause = 1'b1;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_DONE, S_FAULT: state_d = S_IDLE;
            // The outstanding read must complete before the arbiter sees a new request.
            S_DRAIN: begin
                if (mem_ack || timeout_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vaddr_q    <= '0;
            is_instr_q <= 1'b0;
            user_q     <= 1'b0;
            addr_q     <= '0;
            frame_q    <= '0;
            cause_q    <= CAUSE_TIMEOUT;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                vaddr_q    <= miss_vaddr;
                is_instr_q <= miss_is_instr;
                user_q     <= miss_user;
                addr_q     <= {ptbr[19:12], miss_vaddr[31:22], 2'b00};
            end
            if (load_l2)    addr_q  <= {mem_rdata[19:12], vaddr_q[21:12], 2'b00};
            if (load_frame) frame_q <= mem_rdata[19:12];
            if (load_cause) cause_q <= cause_d;
            if (accept || load_l2) cnt_q <= '0;
            else if (mem_req)      cnt_q <= cnt_q + 16'd1;
        end
    end

    assign mem_req           = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_DRAIN);
    assign mem_addr          = addr_q;
    assign miss_ready        = (state_q == S_IDLE) && !flush;
    assign busy              = (state_q != S_IDLE);
    // Strobes are gated by flush so an abort in DONE/FAULT is silent.
    assign tlb_write         = (state_q == S_DONE) && !flush;
    assign page_fault        = (state_q == S_FAULT) && !flush;
    assign tlb_sel_itlb      = is_instr_q;
    assign tlb_logic_page    = {12'b0, vaddr_q[31:12]};
    assign tlb_physical_page = {12'b0, frame_q};
    assign fault_cause       = cause_q;
    assign fault_vaddr       = vaddr_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: walks, faults, wait states, timeout, flush, reset.
// Instance uses TIMEOUT=4; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [19:0] ptbr;
    logic        miss_valid, miss_ready;
    logic [31:0] miss_vaddr;
    logic        miss_is_instr, miss_user;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        tlb_write, tlb_sel_itlb;
    logic [31:0] tlb_logic_page;
    logic [19:0] tlb_physical_page;
    logic        page_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_vaddr;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n_wr = 0;
    int n_pf = 0;

    tlb_refill_walker #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ptbr(ptbr),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vaddr(miss_vaddr),
        .miss_is_instr(miss_is_instr), .miss_user(miss_user),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tlb_write(tlb_write), .tlb_sel_itlb(tlb_sel_itlb), .tlb_logic_page(tlb_logic_page),
        .tlb_physical_page(tlb_physical_page), .page_fault(page_fault),
        .fault_cause(fault_cause), .fault_vaddr(fault_vaddr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Strobe counters used to prove that aborted walks stay silent.
    always @(posedge clk) begin
        if (!reset) begin
            if (tlb_write)  n_wr++;
            if (page_fault) n_pf++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of the most recent walk()
    logic        w_done, w_unstable, w_both, w_req_at_pf, w_sel;
    int          w_wr_cyc, w_pf_cyc, w_wr_cnt, w_pf_cnt, w_req_cycles, w_end_cyc;
    logic [19:0] w_a1, w_a2, w_phys;
    logic        w_seen1, w_seen2;
    logic [31:0] w_logic, w_fv;
    logic [1:0]  w_cause;

    // Issue one miss and serve PTE reads with w1/w2 wait cycles; record what the DUT does.
    task automatic walk(input logic [31:0] va, input logic instr, input logic user,
                        input logic [31:0] pte1, input logic [31:0] pte2,
                        input int w1, input int w2);
        int acks, waitc;
        w_done = 0; w_unstable = 0; w_both = 0; w_req_at_pf = 0; w_sel = 0;
        w_wr_cyc = -1; w_pf_cyc = -1; w_wr_cnt = 0; w_pf_cnt = 0; w_req_cycles = 0; w_end_cyc = -1;
        w_a1 = '0; w_a2 = '0; w_seen1 = 0; w_seen2 = 0; w_phys = '0; w_logic = '0; w_fv = '0; w_cause = '0;
        acks = 0; waitc = 0;
        miss_vaddr = va; miss_is_instr = instr; miss_user = user;
        for (int c = 0; c < 40; c++) begin
            mem_ack = 1'b0;
            miss_valid = (c == 0);
            if (c > 0 && !busy) begin
                w_done = 1; w_end_cyc = c;
                break;
            end
            if (tlb_write) begin
                w_wr_cyc = c; w_wr_cnt++;
                w_sel = tlb_sel_itlb; w_logic = tlb_logic_page; w_phys = tlb_physical_page;
            end
            if (page_fault) begin
                w_pf_cyc = c; w_pf_cnt++;
                w_cause = fault_cause; w_fv = fault_vaddr; w_req_at_pf = mem_req;
            end
            if (tlb_write && page_fault) w_both = 1;
            if (mem_req && c > 0) begin
                w_req_cycles++;
                if (acks == 0) begin
                    if (w_seen1 && mem_addr !== w_a1) w_unstable = 1;
                    w_a1 = mem_addr; w_seen1 = 1;
                end else begin
                    if (w_seen2 && mem_addr !== w_a2) w_unstable = 1;
                    w_a2 = mem_addr; w_seen2 = 1;
                end
                if (waitc == ((acks == 0) ? w1 : w2)) begin
                    mem_ack = 1'b1;
                    mem_rdata = (acks == 0) ? pte1 : pte2;
                    acks++; waitc = 0;
                end else begin
                    waitc++;
                end
            end
            tick();
        end
        mem_ack = 1'b0;
        miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0 || tlb_write !== 1'b0 || page_fault !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: req=%b wr=%b pf=%b busy=%b, want 0000", mem_req, tlb_write, page_fault, busy);
        end
        checks++; if (miss_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", miss_ready);
        end
        checks++; if (mem_addr !== 20'h0 || tlb_logic_page !== 32'h0 || tlb_physical_page !== 20'h0 ||
                      fault_vaddr !== 32'h0 || fault_cause !== 2'b00 || tlb_sel_itlb !== 1'b0) begin
            errors++; $display("FAIL reset_data: addr=%h lp=%h pp=%h fv=%h cause=%b sel=%b, want all 0",
                               mem_addr, tlb_logic_page, tlb_physical_page, fault_vaddr, fault_cause, tlb_sel_itlb);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        ptbr = 20'h05000;
        walk(32'h00403ABC, 1'b1, 1'b0, 32'h00007001, 32'h0002A003, 0, 0);
        checks++; if (w_a1 !== 20'h05004 || w_a2 !== 20'h0700C) begin
            errors++; $display("FAIL hit_addr: l1=%h l2=%h want 05004 0700c", w_a1, w_a2);
        end
        checks++; if (w_wr_cyc !== 3 || w_wr_cnt !== 1 || w_pf_cnt !== 0) begin
            errors++; $display("FAIL hit_write: cyc=%0d wr=%0d pf=%0d want 3 1 0", w_wr_cyc, w_wr_cnt, w_pf_cnt);
        end
        checks++; if (w_sel !== 1'b1 || w_logic !== 32'h00000403 || w_phys !== 20'h0002A) begin
            errors++; $display("FAIL hit_data: sel=%b lp=%h pp=%h want 1 00000403 0002a", w_sel, w_logic, w_phys);
        end
        checks++; if (!w_done || w_end_cyc !== 4 || miss_ready !== 1'b1) begin
            errors++; $display("FAIL hit_ready: done=%b cyc=%0d ready=%b want 1 4 1", w_done, w_end_cyc, miss_ready);
        end
    endtask

    task automatic test_other_vaddr();
        ptbr = 20'hABCDE;
        walk(32'hFFFFF123, 1'b0, 1'b1, 32'h123C5001, 32'hFFF81FFF, 0, 0);
        checks++; if (w_a1 !== 20'hABFFC || w_a2 !== 20'hC5FFC) begin
            errors++; $display("FAIL wide_addr: l1=%h l2=%h want abffc c5ffc", w_a1, w_a2);
        end
        checks++; if (w_wr_cnt !== 1 || w_sel !== 1'b0 || w_logic !== 32'h000FFFFF || w_phys !== 20'h00081) begin
            errors++; $display("FAIL wide_data: wr=%0d sel=%b lp=%h pp=%h want 1 0 000fffff 00081",
                               w_wr_cnt, w_sel, w_logic, w_phys);
        end
    endtask

    task automatic test_l1_invalid();
        ptbr = 20'h05000;
        walk(32'h00403ABC, 1'b0, 1'b0, 32'h00007000, 32'h0002A003, 0, 0);
        checks++; if (w_pf_cyc !== 2 || w_pf_cnt !== 1 || w_cause !== 2'b01 || w_wr_cnt !== 0) begin
            errors++; $display("FAIL l1_fault: cyc=%0d n=%0d cause=%b wr=%0d want 2 1 01 0", w_pf_cyc, w_pf_cnt, w_cause, w_wr_cnt);
        end
        checks++; if (w_fv !== 32'h00403ABC || w_seen2 !== 1'b0) begin
            errors++; $display("FAIL l1_fault_vaddr: fv=%h l2_req=%b want 00403abc 0", w_fv, w_seen2);
        end
    endtask

    task automatic test_l2_faults();
        ptbr = 20'h05000;
        walk(32'h00403ABC, 1'b0, 1'b0, 32'h00007001, 32'h0002A000, 0, 0);
        checks++; if (w_pf_cyc !== 3 || w_cause !== 2'b10 || w_wr_cnt !== 0) begin
            errors++; $display("FAIL l2_invalid: cyc=%0d cause=%b wr=%0d want 3 10 0", w_pf_cyc, w_cause, w_wr_cnt);
        end
        walk(32'h00403ABC, 1'b0, 1'b1, 32'h00007001, 32'h0002A001, 0, 0);
        checks++; if (w_pf_cnt !== 1 || w_cause !== 2'b11 || w_wr_cnt !== 0) begin
            errors++; $display("FAIL perm_user: n=%0d cause=%b wr=%0d want 1 11 0", w_pf_cnt, w_cause, w_wr_cnt);
        end
        walk(32'h00403ABC, 1'b0, 1'b0, 32'h00007001, 32'h0002A001, 0, 0);
        checks++; if (w_wr_cnt !== 1 || w_pf_cnt !== 0 || w_phys !== 20'h0002A) begin
            errors++; $display("FAIL perm_super: wr=%0d pf=%0d pp=%h want 1 0 0002a", w_wr_cnt, w_pf_cnt, w_phys);
        end
    endtask

    task automatic test_wait_states();
        ptbr = 20'h05000;
        walk(32'h00403ABC, 1'b1, 1'b0, 32'h00007001, 32'h0002A003, 3, 3);
        checks++; if (w_wr_cyc !== 9 || w_wr_cnt !== 1 || w_both !== 1'b0) begin
            errors++; $display("FAIL wait_write: cyc=%0d n=%0d both=%b want 9 1 0", w_wr_cyc, w_wr_cnt, w_both);
        end
        checks++; if (w_unstable !== 1'b0 || w_a1 !== 20'h05004 || w_a2 !== 20'h0700C || w_req_cycles !== 8) begin
            errors++; $display("FAIL wait_addr: unstable=%b l1=%h l2=%h reqs=%0d want 0 05004 0700c 8",
                               w_unstable, w_a1, w_a2, w_req_cycles);
        end
    endtask

    task automatic test_timeout();
        int pf0;
        ptbr = 20'h05000;
        walk(32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1000, 1000);
        checks++; if (w_req_cycles !== 4 || w_pf_cyc !== 5 || w_cause !== 2'b00 || w_req_at_pf !== 1'b0) begin
            errors++; $display("FAIL timeout: reqs=%0d cyc=%0d cause=%b req=%b want 4 5 00 0",
                               w_req_cycles, w_pf_cyc, w_cause, w_req_at_pf);
        end
        pf0 = n_pf;
        mem_ack = 1'b1; mem_rdata = 32'h00007001;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || n_pf !== pf0) begin
            errors++; $display("FAIL late_ack: busy=%b req=%b new_pf=%0d want 0 0 0", busy, mem_req, n_pf - pf0);
        end
    endtask

    task automatic test_flush();
        int wr0, pf0;
        ptbr = 20'h05000;
        miss_vaddr = 32'h00403ABC; miss_is_instr = 1'b0; miss_user = 1'b0;
        wr0 = n_wr; pf0 = n_pf;
        // flush in L2, ack two cycles later
        miss_valid = 1'b1; tick(); miss_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h00007001; tick(); mem_ack = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 20'h0700C || busy !== 1'b1) begin
            errors++; $display("FAIL drain_hold: req=%b addr=%h busy=%b want 1 0700c 1", mem_req, mem_addr, busy);
        end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 20'h0700C) begin
            errors++; $display("FAIL drain_hold2: req=%b addr=%h want 1 0700c", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0002A003; tick(); mem_ack = 1'b0;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || miss_ready !== 1'b1) begin
            errors++; $display("FAIL drain_exit: busy=%b req=%b ready=%b want 0 0 1", busy, mem_req, miss_ready);
        end
        // flush coincident with the L1 ack
        miss_valid = 1'b1; tick(); miss_valid = 1'b0;
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h00007001; tick(); flush = 1'b0; mem_ack = 1'b0;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_ack: busy=%b req=%b want 0 0", busy, mem_req);
        end
        // flush in DONE suppresses the write
        miss_valid = 1'b1; tick(); miss_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h00007001; tick();
        mem_rdata = 32'h0002A003; tick(); mem_ack = 1'b0;
        flush = 1'b1; #1;
        checks++; if (tlb_write !== 1'b0) begin
            errors++; $display("FAIL flush_done: wr=%b want 0", tlb_write);
        end
        tick(); flush = 1'b0;
        // flush together with miss_valid in IDLE: miss is not accepted
        flush = 1'b1; miss_valid = 1'b1; tick(); flush = 1'b0; miss_valid = 1'b0;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_idle: busy=%b req=%b want 0 0", busy, mem_req);
        end
        checks++; if (n_wr !== wr0 || n_pf !== pf0) begin
            errors++; $display("FAIL flush_silent: new_wr=%0d new_pf=%0d want 0 0", n_wr - wr0, n_pf - pf0);
        end
    endtask

    task automatic test_reset_mid();
        ptbr = 20'h05000;
        // leave nonzero captured state behind, then reset in L1 of a fresh walk
        walk(32'h00403ABC, 1'b1, 1'b1, 32'h00007001, 32'h0002A001, 0, 0);
        miss_vaddr = 32'hDEADB000; miss_is_instr = 1'b1;
        miss_valid = 1'b1; tick(); miss_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre: req=%b want 1", mem_req);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (mem_req !== 1'b0 || miss_ready !== 1'b1 || busy !== 1'b0 || tlb_write !== 1'b0 || page_fault !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctl: req=%b ready=%b busy=%b wr=%b pf=%b want 0 1 0 0 0",
                               mem_req, miss_ready, busy, tlb_write, page_fault);
        end
        checks++; if (mem_addr !== 20'h0 || tlb_logic_page !== 32'h0 || tlb_physical_page !== 20'h0 ||
                      fault_vaddr !== 32'h0 || fault_cause !== 2'b00 || tlb_sel_itlb !== 1'b0) begin
            errors++; $display("FAIL reset_mid_data: addr=%h lp=%h pp=%h fv=%h cause=%b sel=%b, want all 0",
                               mem_addr, tlb_logic_page, tlb_physical_page, fault_vaddr, fault_cause, tlb_sel_itlb);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ptbr = '0;
        miss_valid = 1'b0; miss_vaddr = '0; miss_is_instr = 1'b0; miss_user = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        test_reset();
        test_hit();
        test_other_vaddr();
        test_l1_invalid();
        test_l2_faults();
        test_wait_states();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_refill_walker.md
# tlb_refill_walker

Hardware page-table walker that services TLB misses for the instruction and data TLBs. It accepts a faulting virtual address, performs a two-level page-table walk over a 20-bit physical memory port, and then does one of two things: drives the TLB write port (logical page plus physical page, one-cycle write strobe), or raises a page fault to the exception unit. It sits between the TLBs and the memory arbiter, replacing the software refill path.

## Interface
- TIMEOUT, 255: max cycles a memory request may wait for `mem_ack` before a timeout fault; 0 disables the timeout.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  abort current walk; no TLB write and no fault for the aborted walk.
- ptbr  in  20  page-table base; only [19:12] is used (L1 table frame).
- miss_valid  in  1  TLB miss request.
- miss_ready  out  1  high only in IDLE; a miss is accepted when `miss_valid && miss_ready`.
- miss_vaddr  in  32  faulting virtual address.
- miss_is_instr  in  1  1 = ITLB miss, 0 = DTLB miss.
- miss_user  in  1  access made in user mode.
- mem_req  out  1  PTE read request, held until `mem_ack`.
- mem_addr  out  20  PTE byte address, stable while `mem_req` is high.
- mem_ack  in  1  read complete; `mem_rdata` is valid in this cycle.
- mem_rdata  in  32  PTE data.
- tlb_write  out  1  one-cycle TLB write strobe.
- tlb_sel_itlb  out  1  target of `tlb_write`: 1 = ITLB, 0 = DTLB.
- tlb_logic_page  out  32  {12'b0, vpn[19:0]}.
- tlb_physical_page  out  20  {12'b0, frame[7:0]}.
- page_fault  out  1  one-cycle fault strobe.
- fault_cause  out  2  00 timeout, 01 L1 invalid, 10 L2 invalid, 11 permission.
- fault_vaddr  out  32  captured `miss_vaddr` of the faulting walk.
- busy  out  1  state != IDLE.

## Operation
- PTE format: [0] valid, [1] user-accessible, [19:12] frame; all other bits are ignored.
- vpn = vaddr[31:12]. L1 address = {ptbr[19:12], vpn[19:10], 2'b00}. L2 address = {pte1[19:12], vpn[9:0], 2'b00}. Widths are exact; there is no carry or overflow.
- States: IDLE, L1, L2, DONE, FAULT, DRAIN.
- IDLE: on accept, capture vaddr, is_instr and user into registers, then go to L1.
- L1: `mem_req`=1 with the L1 address. On ack:
  - pte[0]=0 → FAULT with cause 01.
  - otherwise latch pte1 and go to L2.
- L2: `mem_req`=1 with the L2 address. On ack:
  - pte[0]=0 → FAULT with cause 10.
  - captured user=1 and pte[1]=0 → FAULT with cause 11.
  - otherwise latch the frame and go to DONE.
  - L1 user bit is not checked.
- DONE: `tlb_write`=1 for one cycle with page/frame/sel valid, then IDLE.
- FAULT: `page_fault`=1 for one cycle with cause and vaddr valid, then IDLE.
- Timeout: a per-request counter resets when entering L1 or L2. If it reaches TIMEOUT without ack → FAULT with cause 00, and `mem_req` drops.
- A late ack arriving in IDLE/DONE/FAULT is ignored.
- flush in L1/L2 with no ack that cycle → DRAIN. DRAIN keeps `mem_req` high at the same address until ack, then goes to IDLE. The data is discarded and no strobe is issued. The timeout also applies in DRAIN: expiry → IDLE silently.
- flush in the same cycle as ack → IDLE directly; the ack is consumed and no strobe is issued.
- flush in IDLE has no effect. flush in DONE/FAULT suppresses the strobe.
- flush and miss_valid in the same IDLE cycle: flush wins and the miss is not accepted.
- reset has priority over flush. It forces IDLE immediately, even mid-request.

## Timing
- Reset values:
  - `mem_req`, `tlb_write`, `page_fault`, `busy` = 0.
  - `miss_ready` = 1.
  - `mem_addr`, `tlb_logic_page`, `tlb_physical_page`, `fault_vaddr` = 0.
  - `fault_cause` = 00, `tlb_sel_itlb` = 0.
- All outputs are registered or decoded from state. There is no combinational path from `mem_ack` or `miss_valid` to any output.
- Zero-wait memory (ack in the first cycle of each request):
  - accept at cycle 0,
  - L1 at cycle 1,
  - L2 at cycle 2,
  - `tlb_write` at cycle 3,
  - `miss_ready` high again at cycle 4.
- Each wait cycle on ack adds exactly one cycle.
- An L1 fault with zero-wait memory asserts `page_fault` at cycle 2.
- `tlb_write` and `page_fault` are never high together, and each lasts exactly one cycle per walk.
- `mem_addr` changes only on entry to L1 or L2.

## Test plan
- Hit walk: ptbr=0x05000; vaddr=0x00403ABC, instr=1, user=0.
  - L1 read at 0x05004 returns 0x00007001; L2 read at 0x0700C returns 0x0002A003.
  - Required: `tlb_write` at cycle 3, sel_itlb=1, logic_page=0x00000403, physical_page=0x0002A.
- L1 invalid: L1 PTE 0x00007000 → `page_fault` at cycle 2, cause 01, fault_vaddr equals the captured vaddr, and there is no L2 request.
- Permission: user=1 and L2 PTE 0x0002A001 → cause 11, no `tlb_write`. The same walk with user=0 writes frame 0x2A.
- Wait states and timeout:
  - ack delayed 3 cycles per level → `tlb_write` at cycle 9, with `mem_addr` stable throughout.
  - TIMEOUT=4 and no ack → fault cause 00 after 4 request cycles, and `mem_req` drops.
- Flush mid-request:
  - flush in L2 with ack 2 cycles later → `mem_req` held until ack, then IDLE, with no strobe.
  - flush coincident with ack → IDLE next cycle.
- Reset mid-walk: reset in L1 → next cycle `mem_req`=0, `miss_ready`=1, and all outputs at reset values.
